// File: rtl/keypad_scan_encoder.sv
// 4x3 matrix keypad scanner: synchronises and debounces the rows, then emits one
// single-cycle code per accepted press (4'b1111 when idle).
module keypad_scan_encoder #(
    parameter int unsigned SCAN_DWELL      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [2:0] col_drv,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DW = (SCAN_DWELL > 1) ? $clog2(SCAN_DWELL) : 1;
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [3:0] IDLE_CODE = 4'b1111;
    localparam logic [2:0] COL0_DRV  = 3'b110;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        WAIT_REL = 2'd3
    } state_e;

    state_e          state_q;
    logic [1:0]      col_q;
    logic [1:0]      row_q;
    logic [3:0]      pat_q;
    logic [DW-1:0]   dwell_q;
    logic [CW-1:0]   cnt_q;
    logic [3:0]      sync1_q;
    logic [3:0]      sync2_q;
    logic [2:0]      col_drv_q;
    logic [3:0]      key_code_q;
    logic            key_valid_q;
    logic            key_held_q;
    logic [3:0]      rows_s;
    logic [1:0]      col_nxt;
    logic            dwell_done;
    logic            cnt_done;

    assign rows_s     = sync2_q;
    assign col_nxt    = (col_q == 2'd2) ? 2'd0 : 2'(col_q + 2'd1);
    assign dwell_done = (dwell_q == DW'(SCAN_DWELL - 1));
    assign cnt_done   = (cnt_q == CW'(DEBOUNCE_CYCLES - 1));

    function automatic logic [2:0] col_mask(input logic [1:0] c);
        case (c)
            2'd0:    col_mask = 3'b110;
            2'd1:    col_mask = 3'b101;
            default: col_mask = 3'b011;
        endcase
    endfunction

    function automatic logic [1:0] row_index(input logic [3:0] p);
        case (p)
            4'b1110: row_index = 2'd0;
            4'b1101: row_index = 2'd1;
            4'b1011: row_index = 2'd2;
            default: row_index = 2'd3;
        endcase
    endfunction

    // Digits are row*3+col+1; the bottom row carries the lock's command codes.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        if (r == 2'd3) begin
            case (c)
                2'd0:    key_map = 4'b1110;
                2'd1:    key_map = 4'b1010;
                default: key_map = 4'b1101;
            endcase
        end else begin
            key_map = 4'(4'({2'b00, r}) * 4'd3 + 4'({2'b00, c}) + 4'd1);
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            pat_q       <= 4'b1111;
            dwell_q     <= '0;
            cnt_q       <= '0;
            sync1_q     <= 4'b1111;
            sync2_q     <= 4'b1111;
            col_drv_q   <= COL0_DRV;
            key_code_q  <= IDLE_CODE;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            sync1_q     <= row_in;
            sync2_q     <= sync1_q;
            key_valid_q <= 1'b0;
            key_code_q  <= IDLE_CODE;
            case (state_q)
                SCAN: begin
                    if (dwell_done) begin
                        dwell_q <= '0;
                        if ($onehot(4'(~rows_s))) begin
                            pat_q   <= rows_s;
                            row_q   <= row_index(rows_s);
                            cnt_q   <= '0;
                            state_q <= DEBOUNCE;
                        end else begin
                            col_q     <= col_nxt;
                            col_drv_q <= col_mask(col_nxt);
                        end
                    end else begin
                        dwell_q <= DW'(dwell_q + 1'b1);
                    end
                end
                DEBOUNCE: begin
                    if (rows_s != pat_q) begin
                        col_q     <= col_nxt;
                        col_drv_q <= col_mask(col_nxt);
                        dwell_q   <= '0;
                        state_q   <= SCAN;
                    end else if (cnt_done) begin
                        key_valid_q <= 1'b1;
                        key_code_q  <= key_map(row_q, col_q);
                        key_held_q  <= 1'b1;
                        state_q     <= EMIT;
                    end else begin
                        cnt_q <= CW'(cnt_q + 1'b1);
                    end
                end
                EMIT: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_REL;
                end
                WAIT_REL: begin
                    // Any low row during release restarts the stable-high count.
                    if (rows_s != 4'b1111) begin
                        cnt_q <= '0;
                    end else if (cnt_done) begin
                        key_held_q <= 1'b0;
                        col_q      <= 2'd0;
                        col_drv_q  <= COL0_DRV;
                        dwell_q    <= '0;
                        cnt_q      <= '0;
                        state_q    <= SCAN;
                    end else begin
                        cnt_q <= CW'(cnt_q + 1'b1);
                    end
                end
                default: begin
                    col_q     <= 2'd0;
                    col_drv_q <= COL0_DRV;
                    dwell_q   <= '0;
                    cnt_q     <= '0;
                    state_q   <= SCAN;
                end
            endcase
        end
    end

    assign col_drv   = col_drv_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder with a behavioural 4x3 keypad model.
module tb_keypad_scan_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [2:0]  col_drv;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [11:0] pressed = '0;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int inv_err = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        int         key;
        int         hold;
        logic [3:0] code;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    keypad_scan_encoder #(.SCAN_DWELL(4), .DEBOUNCE_CYCLES(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_in    (row_in),
        .col_drv   (col_drv),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    // Keypad: a pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && !col_drv[c]) row_in[r] = 1'b0;
    end

    // Continuous invariants: idle code when not valid, one-hot-low columns, 1-cycle strobes.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (key_valid) strobe_cnt <= strobe_cnt + 1;
            if ((key_valid && prev_valid) || (!key_valid && key_code != 4'hF) ||
                !(col_drv inside {3'b110, 3'b101, 3'b011}))
                inv_err <= inv_err + 1;
            prev_valid <= key_valid;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_strobe(input int bound, output logic got, output logic [3:0] code);
        got  = 1'b0;
        code = 4'hF;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (key_valid) begin
                got  = 1'b1;
                code = key_code;
                break;
            end
        end
    endtask

    // Release a key cleanly; key_held must drop exactly 16 clocks after rows_s sees it.
    task automatic release_key(input int key, input string name);
        @(posedge clk);
        #1 pressed[key] = 1'b0;
        repeat (18) @(negedge clk);
        check({name, "_held_before"}, int'(key_held), 1);
        @(negedge clk);
        check({name, "_held_after"}, int'(key_held), 0);
    endtask

    task automatic press_key(input int key, input int hold, input logic [3:0] exp, input string name);
        int         s0;
        logic       got;
        logic [3:0] code;
        s0 = strobe_cnt;
        @(posedge clk);
        #1 pressed[key] = 1'b1;
        wait_strobe(300, got, code);
        check({name, "_strobe_seen"}, int'(got), 1);
        check({name, "_code"}, int'(code), int'(exp));
        repeat (hold) @(negedge clk);
        release_key(key, name);
        repeat (4) @(negedge clk);
        check({name, "_strobe_count"}, strobe_cnt - s0, 1);
    endtask

    task automatic check_scan_seq(input int n, input string name);
        int bad;
        logic [2:0] exp;
        bad = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            case ((k / 4) % 3)
                0:       exp = 3'b110;
                1:       exp = 3'b101;
                default: exp = 3'b011;
            endcase
            if (col_drv != exp || key_code != 4'hF || key_valid) bad++;
        end
        check(name, bad, 0);
    endtask

    initial begin
        int         s0;
        logic       got;
        logic [3:0] code;
        int         saw;

        vecs[0] = '{key: 4,  hold: 50, code: 4'd5};
        vecs[1] = '{key: 9,  hold: 30, code: 4'b1110};
        vecs[2] = '{key: 10, hold: 30, code: 4'b1010};
        vecs[3] = '{key: 11, hold: 30, code: 4'b1101};
        vecs[4] = '{key: 8,  hold: 25, code: 4'd9};
        vecs[5] = '{key: 0,  hold: 25, code: 4'd1};

        // Reset values and idle scanning
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_col_drv", int'(col_drv), 3'b110);
        check("rst_key_code", int'(key_code), 4'hF);
        check("rst_key_valid", int'(key_valid), 0);
        check("rst_key_held", int'(key_held), 0);
        rst = 1'b0;
        s0 = strobe_cnt;
        check_scan_seq(100, "idle_scan_seq");
        check("idle_no_strobe", strobe_cnt - s0, 0);

        // Clean presses, one per key, with full releases
        for (int i = 0; i < 6; i++)
            press_key(vecs[i].key, vecs[i].hold, vecs[i].code, $sformatf("vec%0d", i));

        // '7' with short bounce on press and release
        s0 = strobe_cnt;
        for (int i = 0; i < 2; i++) begin
            pressed[6] = 1'b1; repeat (3) @(posedge clk);
            pressed[6] = 1'b0; repeat (3) @(posedge clk);
        end
        pressed[6] = 1'b1;
        wait_strobe(300, got, code);
        check("bounce7_strobe_seen", int'(got), 1);
        check("bounce7_code", int'(code), 4'd7);
        repeat (30) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            pressed[6] = 1'b0; repeat (3) @(posedge clk);
            pressed[6] = 1'b1; repeat (3) @(posedge clk);
        end
        pressed[6] = 1'b0;
        saw = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!key_held) begin saw = 1; break; end
        end
        check("bounce7_released", saw, 1);
        repeat (5) @(negedge clk);
        check("bounce7_strobe_count", strobe_cnt - s0, 1);

        // Two rows low in one column is ambiguous and must be ignored
        s0 = strobe_cnt;
        pressed[0] = 1'b1;
        pressed[6] = 1'b1;
        saw = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (col_drv == 3'b011) saw = 1;
        end
        check("ambig_scan_continues", saw, 1);
        check("ambig_no_strobe", strobe_cnt - s0, 0);
        pressed[0] = 1'b0;
        pressed[6] = 1'b0;
        repeat (10) @(negedge clk);

        // Hold '1', add '3': only '1' now, '3' after '1' is released
        s0 = strobe_cnt;
        pressed[0] = 1'b1;
        wait_strobe(300, got, code);
        check("hold1_code", int'(code), 4'd1);
        repeat (20) @(negedge clk);
        pressed[2] = 1'b1;
        repeat (60) @(negedge clk);
        check("hold1_no_repeat", strobe_cnt - s0, 1);
        pressed[0] = 1'b0;
        wait_strobe(300, got, code);
        check("after1_strobe_seen", int'(got), 1);
        check("after1_code", int'(code), 4'd3);
        repeat (20) @(negedge clk);
        release_key(2, "rel3");
        repeat (4) @(negedge clk);
        check("hold1_total_strobes", strobe_cnt - s0, 2);

        // Reset mid-DEBOUNCE, then mid-EMIT; '2' held from reset gives a fixed timeline
        @(posedge clk);
        #1 rst = 1'b1;
        pressed[1] = 1'b1;
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (13) @(negedge clk);
        check("deb_col_before_rst", int'(col_drv), 3'b101);
        #1 rst = 1'b1;
        #1;
        check("deb_rst_col_drv", int'(col_drv), 3'b110);
        check("deb_rst_key_held", int'(key_held), 0);
        check("deb_rst_key_code", int'(key_code), 4'hF);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (24) @(negedge clk);
        check("latency_not_yet", int'(key_valid), 0);
        @(negedge clk);
        check("latency_valid", int'(key_valid), 1);
        check("latency_code", int'(key_code), 4'd2);
        #2 rst = 1'b1;
        #1;
        check("emit_rst_key_valid", int'(key_valid), 0);
        check("emit_rst_key_code", int'(key_code), 4'hF);
        check("emit_rst_key_held", int'(key_held), 0);
        check("emit_rst_col_drv", int'(col_drv), 3'b110);
        pressed[1] = 1'b0;
        s0 = strobe_cnt;
        repeat (3) @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        check_scan_seq(24, "post_rst_scan_seq");
        check("post_rst_no_strobe", strobe_cnt - s0, 0);

        repeat (2) @(negedge clk);
        check("invariants", inv_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
